// File: rtl/apb_pkg.sv
// Shared APB definitions: bridge FSM states and default bus widths.
// Used by apb_master_bridge, apb_ram and the benches.
package apb_pkg;

    localparam int unsigned APB_ADDR_WIDTH = 8;
    localparam int unsigned APB_DATA_WIDTH = 32;

    typedef enum logic [1:0] {
        StIdle,
        StSetup,
        StAccess,
        StResp
    } apb_state_e;

endpackage

// File: rtl/apb_master_bridge_if.sv
// Command/response channels plus APB bus seen by apb_master_bridge.
// master = bridge side, slave = environment side (command source, consumer, APB slave).
interface apb_master_bridge_if
    import apb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = APB_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = APB_DATA_WIDTH
) ();

    logic                  cmd_valid;
    logic                  cmd_ready;
    logic                  cmd_write;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic [DATA_WIDTH-1:0] cmd_wdata;

    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic                  rsp_err;

    logic                  PSEL;
    logic                  PENABLE;
    logic                  PWRITE;
    logic [ADDR_WIDTH-1:0] PADDR;
    logic [DATA_WIDTH-1:0] PWDATA;
    logic [DATA_WIDTH-1:0] PRDATA;
    logic                  PREADY;
    logic                  PSLVERR;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
        input  PRDATA, PREADY, PSLVERR,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err,
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
        output PRDATA, PREADY, PSLVERR,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err,
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA
    );

endinterface

// File: rtl/apb_timeout_cnt.sv
// ACCESS-phase wait counter: cleared before ACCESS, counts stalled cycles,
// flags the stalled cycle that reaches LIMIT.
module apb_timeout_cnt #(
    parameter int unsigned LIMIT = 16
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    localparam int unsigned W = $clog2(LIMIT + 1);
    localparam logic [W-1:0] LAST = W'(LIMIT - 1);

    logic [W-1:0] r_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (i_enable) begin
            r_cnt <= r_cnt + W'(1);
        end
    end

    // Combinational so a PREADY in the same cycle can still take priority.
    assign o_expired = i_enable && (r_cnt == LAST);

endmodule

// File: rtl/apb_master_bridge.sv
// Single-outstanding APB master: valid/ready command in, APB SETUP/ACCESS out, response back.
// Optional ACCESS timeout compiled in with APB_MASTER_TIMEOUT_EN.
module apb_master_bridge
    import apb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = APB_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH     = APB_DATA_WIDTH,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input logic                  PCLK,
    input logic                  PRESETn,
    apb_master_bridge_if.master  bus
);

    if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be nonzero");
    end

    apb_state_e            r_state, w_state_d;
    logic                  r_cmd_ready, w_cmd_ready_d;
    logic                  r_psel, w_psel_d;
    logic                  r_penable, w_penable_d;
    logic                  r_pwrite, w_pwrite_d;
    logic [ADDR_WIDTH-1:0] r_paddr, w_paddr_d;
    logic [DATA_WIDTH-1:0] r_pwdata, w_pwdata_d;
    logic                  r_rsp_valid, w_rsp_valid_d;
    logic [DATA_WIDTH-1:0] r_rsp_rdata, w_rsp_rdata_d;
    logic                  r_rsp_err, w_rsp_err_d;
    logic                  w_timeout;

`ifdef APB_MASTER_TIMEOUT_EN
    logic w_to_clear, w_to_enable;

    assign w_to_clear  = (r_state == StSetup);
    assign w_to_enable = (r_state == StAccess) && !bus.PREADY;

    apb_timeout_cnt #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timeout_cnt (
        .i_clk     (PCLK),
        .i_rst_n   (PRESETn),
        .i_clear   (w_to_clear),
        .i_enable  (w_to_enable),
        .o_expired (w_timeout)
    );
`else
    assign w_timeout = 1'b0;
`endif

    always_comb begin
        w_state_d     = r_state;
        w_cmd_ready_d = r_cmd_ready;
        w_psel_d      = r_psel;
        w_penable_d   = r_penable;
        w_pwrite_d    = r_pwrite;
        w_paddr_d     = r_paddr;
        w_pwdata_d    = r_pwdata;
        w_rsp_valid_d = r_rsp_valid;
        w_rsp_rdata_d = r_rsp_rdata;
        w_rsp_err_d   = r_rsp_err;

        unique case (r_state)
            StIdle: begin
                if (bus.cmd_valid && r_cmd_ready) begin
                    w_state_d     = StSetup;
                    w_cmd_ready_d = 1'b0;
                    w_psel_d      = 1'b1;
                    w_pwrite_d    = bus.cmd_write;
                    w_paddr_d     = bus.cmd_addr;
                    w_pwdata_d    = bus.cmd_wdata;
                end
            end
            StSetup: begin
                w_state_d   = StAccess;
                w_penable_d = 1'b1;
            end
            StAccess: begin
                if (bus.PREADY || w_timeout) begin
                    w_state_d     = StResp;
                    w_psel_d      = 1'b0;
                    w_penable_d   = 1'b0;
                    w_rsp_valid_d = 1'b1;
                    if (bus.PREADY) begin
                        w_rsp_rdata_d = r_pwrite ? '0 : bus.PRDATA;
                        w_rsp_err_d   = bus.PSLVERR;
                    end else begin
                        w_rsp_rdata_d = '0;
                        w_rsp_err_d   = 1'b1;
                    end
                end
            end
            StResp: begin
                if (bus.rsp_ready) begin
                    w_state_d     = StIdle;
                    w_rsp_valid_d = 1'b0;
                    w_cmd_ready_d = 1'b1;
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_state     <= StIdle;
            r_cmd_ready <= 1'b1;
            r_psel      <= 1'b0;
            r_penable   <= 1'b0;
            r_pwrite    <= 1'b0;
            r_paddr     <= '0;
            r_pwdata    <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            r_state     <= w_state_d;
            r_cmd_ready <= w_cmd_ready_d;
            r_psel      <= w_psel_d;
            r_penable   <= w_penable_d;
            r_pwrite    <= w_pwrite_d;
            r_paddr     <= w_paddr_d;
            r_pwdata    <= w_pwdata_d;
            r_rsp_valid <= w_rsp_valid_d;
            r_rsp_rdata <= w_rsp_rdata_d;
            r_rsp_err   <= w_rsp_err_d;
        end
    end

    assign bus.cmd_ready = r_cmd_ready;
    assign bus.PSEL      = r_psel;
    assign bus.PENABLE   = r_penable;
    assign bus.PWRITE    = r_pwrite;
    assign bus.PADDR     = r_paddr;
    assign bus.PWDATA    = r_pwdata;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_rdata = r_rsp_rdata;
    assign bus.rsp_err   = r_rsp_err;

endmodule
